// File: rtl/meas_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// meas_pkg: measurement FSM states and default widths, shared with the strobe generator. Rev 1.0
// ----------------------------------------------------------------------------
package meas_pkg;

  typedef logic [1:0] meas_state_t;

  localparam meas_state_t ST_IDLE    = 2'd0;
  localparam meas_state_t ST_ACQUIRE = 2'd1;
  localparam meas_state_t ST_TRACK   = 2'd2;
  localparam meas_state_t ST_REQUEST = 2'd3;

  localparam int unsigned MEAS_T_CNT_WIDTH    = 32;
  localparam int unsigned MEAS_TOL_WIDTH      = 8;
  localparam int unsigned MEAS_STABLE_PERIODS = 2;
  localparam int unsigned MEAS_LOST_CYCLES    = 2 ** 20;

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sync_edge: two-flop synchronizer followed by a rising-edge detector. Rev 1.0
// ----------------------------------------------------------------------------
module sync_edge (
  input  logic clk_i,
  input  logic arst_i,
  input  logic d_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // All flops clear together, so reset itself never looks like an edge.
  assign rise_o = sync_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/freq_mon.sv
`default_nettype none
// ----------------------------------------------------------------------------
// freq_mon: measures sig_i period, accepts stable periods as reference, requests re-measure. Rev 1.0
// ----------------------------------------------------------------------------
module freq_mon
  import meas_pkg::*;
#(
  parameter int unsigned T_CNT_WIDTH    = MEAS_T_CNT_WIDTH,
  parameter int unsigned TOL_WIDTH      = MEAS_TOL_WIDTH,
  parameter int unsigned STABLE_PERIODS = MEAS_STABLE_PERIODS,
  parameter int unsigned LOST_CYCLES    = MEAS_LOST_CYCLES
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   sig_i,
  input  logic                   en_i,
  input  logic [TOL_WIDTH-1:0]   tol_i,
  input  logic                   rdy_i,
  output logic                   freq_det_o,
  output logic [T_CNT_WIDTH-1:0] period_o,
  output logic                   period_vld_o,
  output logic [T_CNT_WIDTH-1:0] ref_o,
  output logic                   lost_o
);

  localparam int unsigned STB_W = $clog2(STABLE_PERIODS + 1);
  localparam logic [T_CNT_WIDTH-1:0] LOST_VAL   = T_CNT_WIDTH'(LOST_CYCLES);
  localparam logic [STB_W-1:0]       STB_ACCEPT = STB_W'(STABLE_PERIODS);

  function automatic logic [T_CNT_WIDTH-1:0] abs_diff(input logic [T_CNT_WIDTH-1:0] a,
                                                      input logic [T_CNT_WIDTH-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic                   rise;
  logic [T_CNT_WIDTH-1:0] tol_ext;

  meas_state_t            state_q, state_d;
  logic [T_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [T_CNT_WIDTH-1:0] cand_q, cand_d;
  logic [STB_W-1:0]       stable_q, stable_d;
  logic [T_CNT_WIDTH-1:0] ref_q, ref_d;
  logic [T_CNT_WIDTH-1:0] period_q, period_d;
  logic                   have_edge_q, have_edge_d;
  logic                   lost_q, lost_d;
  logic                   freq_det_q, freq_det_d;
  logic                   period_vld_q, period_vld_d;

  logic                   accept;
  logic                   loss;
  logic [STB_W-1:0]       stable_nx;

  sync_edge u_sync_edge (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .d_i    (sig_i),
    .rise_o (rise)
  );

  assign tol_ext = T_CNT_WIDTH'(tol_i);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cand_d       = cand_q;
    stable_d     = stable_q;
    ref_d        = ref_q;
    period_d     = period_q;
    have_edge_d  = have_edge_q;
    lost_d       = lost_q;
    freq_det_d   = 1'b0;
    period_vld_d = 1'b0;
    accept       = 1'b0;
    loss         = 1'b0;
    stable_nx    = '0;

    if (!en_i || state_q == ST_IDLE) begin
      cnt_d       = '0;
      cand_d      = '0;
      stable_d    = '0;
      lost_d      = 1'b0;
      have_edge_d = 1'b0;
      state_d     = en_i ? ST_ACQUIRE : ST_IDLE;
    end else begin
      if (rise) begin
        cnt_d       = T_CNT_WIDTH'(1);
        lost_d      = 1'b0;
        have_edge_d = 1'b1;
        // The first edge after enable or loss only starts the count.
        if (have_edge_q) begin
          period_d     = cnt_q;
          period_vld_d = 1'b1;
          if (state_q != ST_ACQUIRE && abs_diff(cnt_q, ref_q) <= tol_ext) begin
            stable_d = '0;
          end else begin
            if (abs_diff(cnt_q, cand_q) <= tol_ext) begin
              stable_nx = stable_q + STB_W'(1);
            end else begin
              cand_d    = cnt_q;
              stable_nx = STB_W'(1);
            end
            if (stable_nx == STB_ACCEPT) begin
              ref_d    = cand_d;
              stable_d = '0;
              accept   = 1'b1;
            end else begin
              stable_d = stable_nx;
            end
          end
        end
      end else if (cnt_q == LOST_VAL) begin
        if (!lost_q) begin
          loss        = 1'b1;
          lost_d      = 1'b1;
          ref_d       = '0;
          cand_d      = '0;
          stable_d    = '0;
          have_edge_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + T_CNT_WIDTH'(1);
      end

      // Loss pre-empts a pending request; a re-acceptance while waiting adds no pulse.
      if (loss) begin
        state_d = ST_ACQUIRE;
      end else if (state_q == ST_REQUEST && rdy_i) begin
        freq_det_d = 1'b1;
        state_d    = ST_TRACK;
      end else if (accept) begin
        state_d = ST_REQUEST;
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      cand_q       <= '0;
      stable_q     <= '0;
      ref_q        <= '0;
      period_q     <= '0;
      have_edge_q  <= 1'b0;
      lost_q       <= 1'b0;
      freq_det_q   <= 1'b0;
      period_vld_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cand_q       <= cand_d;
      stable_q     <= stable_d;
      ref_q        <= ref_d;
      period_q     <= period_d;
      have_edge_q  <= have_edge_d;
      lost_q       <= lost_d;
      freq_det_q   <= freq_det_d;
      period_vld_q <= period_vld_d;
    end
  end

  assign freq_det_o   = freq_det_q;
  assign period_o     = period_q;
  assign period_vld_o = period_vld_q;
  assign ref_o        = ref_q;
  assign lost_o       = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_mon.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_freq_mon: directed and randomized period stimulus against a timestamp-based reference model. Rev 1.0
// ----------------------------------------------------------------------------
module tb_freq_mon;

  localparam int TW = 32;
  localparam int OW = 8;
  localparam int SP = 2;
  localparam int LC = 1000;

  logic          clk_i = 1'b0;
  logic          arst_i;
  logic          sig_i;
  logic          en_i;
  logic [OW-1:0] tol_i;
  logic          rdy_i;
  logic          freq_det_o;
  logic [TW-1:0] period_o;
  logic          period_vld_o;
  logic [TW-1:0] ref_o;
  logic          lost_o;

  always #5 clk_i = ~clk_i;

  freq_mon #(
    .T_CNT_WIDTH    (TW),
    .TOL_WIDTH      (OW),
    .STABLE_PERIODS (SP),
    .LOST_CYCLES    (LC)
  ) dut (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .sig_i        (sig_i),
    .en_i         (en_i),
    .tol_i        (tol_i),
    .rdy_i        (rdy_i),
    .freq_det_o   (freq_det_o),
    .period_o     (period_o),
    .period_vld_o (period_vld_o),
    .ref_o        (ref_o),
    .lost_o       (lost_o)
  );

  int checks = 0;
  int passes = 0;
  int det_cnt = 0;
  bit rand_rdy = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: the counter is a timestamp difference, states are plain labels.
  typedef enum int {M_IDLE, M_ACQ, M_TRACK, M_REQ} mst_e;
  mst_e   m_st = M_IDLE;
  longint cyc = 0, t0 = 0, m_period = 0, m_ref = 0, m_cand = 0;
  int     m_stable = 0;
  bit     m_have = 0, m_lost = 0, m_det = 0, m_vld = 0;
  bit     h1 = 0, h2 = 0, h3 = 0;

  function automatic longint dev(input longint a, input longint b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic model_step();
    bit     edge_now, loss, accepted;
    mst_e   old;
    longint cnt;
    edge_now = h2 && !h3;
    h3 = h2; h2 = h1; h1 = sig_i;
    if (arst_i) begin
      h1 = 0; h2 = 0; h3 = 0;
      m_st = M_IDLE; m_period = 0; m_ref = 0; m_cand = 0; m_stable = 0;
      m_have = 0; m_lost = 0; m_det = 0; m_vld = 0; t0 = cyc;
      return;
    end
    m_det = 0; m_vld = 0; old = m_st; loss = 0; accepted = 0;
    if (!en_i || old == M_IDLE) begin
      t0 = cyc; m_cand = 0; m_stable = 0; m_lost = 0; m_have = 0;
      m_st = en_i ? M_ACQ : M_IDLE;
      return;
    end
    cnt = cyc - 1 - t0;
    if (cnt > LC) cnt = LC;
    if (edge_now) begin
      if (m_have) begin
        m_period = cnt; m_vld = 1;
        if (old != M_ACQ && dev(cnt, m_ref) <= longint'(tol_i)) m_stable = 0;
        else begin
          if (dev(cnt, m_cand) <= longint'(tol_i)) m_stable++;
          else begin m_cand = cnt; m_stable = 1; end
          if (m_stable == SP) begin m_ref = m_cand; m_stable = 0; accepted = 1; end
        end
      end
      m_have = 1; m_lost = 0; t0 = cyc - 1;
    end else if (cnt == LC && !m_lost) begin
      loss = 1; m_lost = 1; m_ref = 0; m_cand = 0; m_stable = 0; m_have = 0;
    end
    if (loss) m_st = M_ACQ;
    else if (old == M_REQ && rdy_i) begin m_det = 1; m_st = M_TRACK; end
    else if (accepted) m_st = M_REQ;
  endtask

  always @(posedge clk_i) begin
    cyc++;
    model_step();
    #1;
    chk("freq_det_o", longint'(freq_det_o), longint'(m_det));
    chk("period_vld_o", longint'(period_vld_o), longint'(m_vld));
    chk("period_o", longint'(period_o), m_period);
    chk("ref_o", longint'(ref_o), m_ref);
    chk("lost_o", longint'(lost_o), longint'(m_lost));
    if (freq_det_o) det_cnt++;
  end

  task automatic tick();
    if (rand_rdy) rdy_i = ($urandom_range(0, 3) != 0);
    @(negedge clk_i);
  endtask

  task automatic drive_period(input int p);
    sig_i = 1'b1;
    for (int i = 0; i < p; i++) begin
      if (i == p / 2) sig_i = 1'b0;
      tick();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    arst_i = 1'b1; sig_i = 1'b0; en_i = 1'b0; rdy_i = 1'b1; tol_i = 8'd2;
    repeat (3) @(negedge clk_i);
    chk("rst_period", longint'(period_o), 0);
    chk("rst_ref", longint'(ref_o), 0);
    chk("rst_lost", longint'(lost_o), 0);
    chk("rst_det", longint'(freq_det_o), 0);
    arst_i = 1'b0;
    @(negedge clk_i);
    en_i = 1'b1;
    @(negedge clk_i);

    // Lock to 100
    det_cnt = 0;
    repeat (3) drive_period(100);
    chk("lock100_ref", longint'(ref_o), 100);
    chk("lock100_period", longint'(period_o), 100);
    chk("lock100_pulses", det_cnt, 1);

    // Jitter inside tolerance
    det_cnt = 0;
    for (int k = 0; k < 6; k++) drive_period((k % 2 == 1) ? 101 : 99);
    chk("jitter_pulses", det_cnt, 0);
    chk("jitter_ref", longint'(ref_o), 100);

    // Switch to 150
    det_cnt = 0;
    repeat (3) drive_period(150);
    chk("sw150_ref", longint'(ref_o), 150);
    chk("sw150_pulses", det_cnt, 1);

    // Switch to 200 with downstream busy
    det_cnt = 0;
    rdy_i = 1'b0;
    repeat (5) drive_period(200);
    chk("busy200_pulses", det_cnt, 0);
    chk("busy200_ref", longint'(ref_o), 200);
    rdy_i = 1'b1;
    repeat (5) @(negedge clk_i);
    chk("rdy200_pulses", det_cnt, 1);

    // One edge, then silence until loss
    sig_i = 1'b1;
    for (int i = 0; i < 1010; i++) begin
      if (i == 50) sig_i = 1'b0;
      if (i == 995) chk("lost_early", longint'(lost_o), 0);
      @(negedge clk_i);
    end
    chk("lost_set", longint'(lost_o), 1);
    chk("lost_ref", longint'(ref_o), 0);

    // Restart at 100
    det_cnt = 0;
    repeat (4) drive_period(100);
    chk("reacq_lost", longint'(lost_o), 0);
    chk("reacq_ref", longint'(ref_o), 100);
    chk("reacq_pulses", det_cnt, 1);

    // Disable mid-track
    en_i = 1'b0;
    repeat (10) @(negedge clk_i);
    chk("dis_period_held", longint'(period_o), 100);
    chk("dis_ref_held", longint'(ref_o), 100);
    en_i = 1'b1;

    // Reset while a request is pending
    rdy_i = 1'b0;
    repeat (3) drive_period(150);
    chk("req150_ref", longint'(ref_o), 150);
    #2 arst_i = 1'b1;
    #1;
    chk("arst_period", longint'(period_o), 0);
    chk("arst_ref", longint'(ref_o), 0);
    chk("arst_vld", longint'(period_vld_o), 0);
    chk("arst_det", longint'(freq_det_o), 0);
    chk("arst_lost", longint'(lost_o), 0);
    repeat (3) @(negedge clk_i);
    arst_i = 1'b0;
    rdy_i = 1'b1;
    det_cnt = 0;
    repeat (50) @(negedge clk_i);
    chk("arst_no_pulse", det_cnt, 0);

    // Randomized segments
    rand_rdy = 1'b1;
    for (int s = 0; s < 30; s++) begin
      int base, n, r;
      base = int'($urandom_range(20, 300));
      n = int'($urandom_range(1, 6));
      r = int'($urandom_range(0, 19));
      tol_i = 8'($urandom_range(0, 5));
      if (r == 0) begin
        en_i = 1'b0;
        idle(int'($urandom_range(1, 20)));
        en_i = 1'b1;
      end else if (r == 1) begin
        idle(1100);
      end else if (r == 2) begin
        arst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        arst_i = 1'b0;
      end
      for (int j = 0; j < n; j++) drive_period(base + int'($urandom_range(0, 6)) - 3);
    end
    rand_rdy = 1'b0;

    repeat (5) @(negedge clk_i);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/freq_mon.md
FREQ_MON -- requirements
Module: freq_mon

Interface
REQ-001 Parameter T_CNT_WIDTH, default 32: width of period counter and period output.
REQ-002 Parameter TOL_WIDTH, default 8: width of tolerance input.
REQ-003 Parameter STABLE_PERIODS, default 2: consecutive in-tolerance periods needed to accept a new period.
REQ-004 Parameter LOST_CYCLES, default 2**20: cycles without a rising edge that declare signal loss.
REQ-005 clk_i  input  1  clock, all logic on rising edge.
REQ-006 arst_i  input  1  reset, asynchronous, active-high.
REQ-007 sig_i  input  1  monitored signal, asynchronous to clk_i.
REQ-008 en_i  input  1  monitor enable, level.
REQ-009 tol_i  input  TOL_WIDTH  allowed period deviation in cycles, unsigned.
REQ-010 rdy_i  input  1  downstream strobe generator idle and able to accept a re-measure request.
REQ-011 freq_det_o  output  1  one-cycle re-measure request to the strobe generator.
REQ-012 period_o  output  T_CNT_WIDTH  last measured period in clk_i cycles.
REQ-013 period_vld_o  output  1  one-cycle pulse, period_o updated.
REQ-014 ref_o  output  T_CNT_WIDTH  currently accepted reference period.
REQ-015 lost_o  output  1  signal-loss flag, level.

Function
REQ-016 sig_i SHALL pass a 2-flop synchronizer; a rising edge is synchronized 0 then 1 on consecutive cycles.
REQ-017 Period SHALL be the number of clk_i cycles between consecutive detected rising edges; counter loads 1 on an edge, increments otherwise, saturates at LOST_CYCLES.
REQ-018 Each detected edge after the first SHALL load period_o with the counter value and pulse period_vld_o in the same register update.
REQ-019 Deviation SHALL be the unsigned absolute difference at T_CNT_WIDTH, zero-extended tol_i; in tolerance means deviation <= tol_i.
REQ-020 States: IDLE, ACQUIRE, TRACK, REQUEST.
REQ-021 IDLE: entered whenever en_i=0, from any state, next cycle; clears counters, candidate, lost_o, freq_det_o; holds period_o and ref_o; en_i=1 -> ACQUIRE.
REQ-022 ACQUIRE: each period compared with candidate; in tolerance increments stable count, else candidate<=period and stable count<=1; when stable count reaches STABLE_PERIODS, ref_o<=candidate and -> REQUEST.
REQ-023 TRACK: period in tolerance of ref_o clears stable count; out of tolerance runs the REQ-022 candidate procedure; acceptance updates ref_o and -> REQUEST.
REQ-024 REQUEST: freq_det_o=1 for exactly one cycle, the first cycle with rdy_i=1, then -> TRACK; rdy_i=0 holds REQUEST indefinitely.
REQ-025 In REQUEST, edges SHALL still update period_o and run candidate tracking; a further acceptance updates ref_o without extra pulse; at most one pulse per REQUEST visit.
REQ-026 Counter reaching LOST_CYCLES SHALL set lost_o, invalidate ref (ref_o<=0), clear candidate and -> ACQUIRE, also from REQUEST without a pulse.
REQ-027 lost_o SHALL clear on the next detected edge; that edge produces no period_o update.
REQ-028 Edge and loss threshold in the same cycle: edge wins, no loss.
REQ-029 tol_i changes SHALL take effect on the next compare, no restart.

Reset
REQ-030 arst_i SHALL force IDLE, counters, candidate, period_o, ref_o=0, freq_det_o, period_vld_o, lost_o=0, and synchronizer flops to 0, at any time including mid-REQUEST.
REQ-031 After deassertion, first edge SHALL need two synchronizer cycles; no false edge from reset values.

Structure
REQ-032 State enum and default width constants SHALL reside in shared package meas_pkg, also used by the strobe generator.
REQ-033 Synchronizer plus edge detector SHALL be sub-module sync_edge (ports clk_i, arst_i, d_i, rise_o).

Verification
REQ-034 sig_i period 100 cycles, tol_i=2, rdy_i=1, en_i=1 -> period_vld_o every 100 cycles with period_o=100; after 3rd edge ref_o=100, one freq_det_o pulse.
REQ-035 Locked at 100, switch to 150 -> two periods 150 then ref_o=150, one pulse; jitter 99/101 produces no pulse.
REQ-036 Change 100->200 with rdy_i=0 for 1000 cycles -> no pulse until rdy_i rises, then exactly one pulse, ref_o=200.
REQ-037 LOST_CYCLES=1000, stop sig_i -> lost_o=1 at 1000 cycles after last edge, ref_o=0; restart 100 -> lost_o clears at first edge, reacquire and pulse.
REQ-038 arst_i in REQUEST, rdy_i=0 -> all outputs 0, no pulse after release; en_i toggled low mid-TRACK -> IDLE, period_o held.
